// File: rtl/dimmer_pkg.sv
// Shared types and constants for the LED dimmer controller.
//   dim_state_t : brightness controller mode (manual stepping or breathe ramp)
//   dim_dbg_t   : observation bundle exported by led_dimmer_ctrl
//   DUTY_W / DUTY_MAX / DUTY_MIN : width and endpoints of the duty word
package dimmer_pkg;

    localparam int DUTY_W = 4;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 4'd15;
    localparam logic [DUTY_W-1:0] DUTY_MIN = 4'd0;

    typedef enum logic [1:0] {
        MANUAL    = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } dim_state_t;

    // Internal observation points: FSM state, debounced button levels and
    // the synchronized breathe enable.
    typedef struct packed {
        dim_state_t state;
        logic       up_level;
        logic       down_level;
        logic       breathe;
    } dim_dbg_t;

endpackage

// File: rtl/btn_debounce.sv
// Debouncer for one raw push-button.
//   clk       in  : system clock
//   reset     in  : synchronous, active-low reset
//   btn_raw   in  : raw asynchronous, bouncy button level
//   btn_level out : debounced level
//   press     out : one-cycle pulse on a rising edge of btn_level
module btn_debounce
    import dimmer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_1  <= btn_raw;
            sync_2  <= sync_1;
            level_d <= level;
            // The counter only advances while the synchronized input
            // disagrees with the accepted level; any agreement restarts it,
            // so a glitch must persist unbroken to be accepted.
            if (sync_2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign btn_level = level;
    assign press     = level & ~level_d;

endmodule

// File: rtl/led_dimmer_ctrl.sv
// LED brightness controller feeding pwm_top.duty_cycle.
//   clk        in  : system clock (single domain)
//   reset      in  : synchronous, active-low reset
//   btn_up     in  : raw button, one step brighter per press
//   btn_down   in  : raw button, one step dimmer per press
//   breathe_en in  : level, 1 selects autonomous up/down ramp
//   duty_cycle out : registered brightness 0..15
//   at_max     out : registered, 1 iff duty_cycle == 15
//   at_min     out : registered, 1 iff duty_cycle == 0
//   dbg        out : FSM state, debounced levels, synchronized breathe_en
module led_dimmer_ctrl
    import dimmer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STEP_TICKS      = 2500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              breathe_en,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              at_max,
    output logic              at_min,
    output dim_dbg_t          dbg
);

    localparam int TICK_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_TICKS - 1);

    logic press_up, press_down;
    logic up_level, down_level;
    logic breathe_1, breathe_s;

    dim_state_t        state, state_n;
    logic [DUTY_W-1:0] duty, duty_n;
    logic [TICK_W-1:0] tick, tick_n;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_up),
        .btn_level (up_level),
        .press     (press_up)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_down),
        .btn_level (down_level),
        .press     (press_down)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            breathe_1 <= 1'b0;
            breathe_s <= 1'b0;
            state     <= MANUAL;
            duty      <= DUTY_MIN;
            tick      <= '0;
            at_max    <= 1'b0;
            at_min    <= 1'b1;
        end else begin
            breathe_1 <= breathe_en;
            breathe_s <= breathe_1;
            state     <= state_n;
            duty      <= duty_n;
            tick      <= tick_n;
            // Flags come from the next value so they never lag duty_cycle.
            at_max    <= (duty_n == DUTY_MAX);
            at_min    <= (duty_n == DUTY_MIN);
        end
    end

    always_comb begin
        state_n = state;
        duty_n  = duty;
        tick_n  = tick;
        case (state)
            MANUAL: begin
                tick_n = '0;
                // Presses arriving in the entry cycle are dropped on purpose.
                if (breathe_s) begin
                    state_n = (duty == DUTY_MAX) ? RAMP_DOWN : RAMP_UP;
                end else if (press_up && !press_down && duty != DUTY_MAX) begin
                    duty_n = duty + 1'b1;
                end else if (press_down && !press_up && duty != DUTY_MIN) begin
                    duty_n = duty - 1'b1;
                end
            end
            RAMP_UP: begin
                if (!breathe_s) begin
                    state_n = MANUAL;
                    tick_n  = '0;
                end else if (tick == TICK_LAST) begin
                    tick_n = '0;
                    duty_n = duty + 1'b1;
                    // Turn around on the step that lands on the endpoint so
                    // the endpoint is held for one full step period.
                    if (duty_n == DUTY_MAX) state_n = RAMP_DOWN;
                end else begin
                    tick_n = tick + 1'b1;
                end
            end
            RAMP_DOWN: begin
                if (!breathe_s) begin
                    state_n = MANUAL;
                    tick_n  = '0;
                end else if (tick == TICK_LAST) begin
                    tick_n = '0;
                    duty_n = duty - 1'b1;
                    if (duty_n == DUTY_MIN) state_n = RAMP_UP;
                end else begin
                    tick_n = tick + 1'b1;
                end
            end
            default: begin
                state_n = MANUAL;
                tick_n  = '0;
            end
        endcase
    end

    assign duty_cycle     = duty;
    assign dbg.state      = state;
    assign dbg.up_level   = up_level;
    assign dbg.down_level = down_level;
    assign dbg.breathe    = breathe_s;

endmodule

// File: tb/tb_led_dimmer_ctrl.sv
// Self-checking bench for led_dimmer_ctrl with short debounce/step periods.
module tb_led_dimmer_ctrl;
    import dimmer_pkg::*;

    localparam int DEB  = 4;
    localparam int STEP = 3;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       breathe_en = 1'b0;
    logic [3:0] duty_cycle;
    logic       at_max;
    logic       at_min;
    dim_dbg_t   dbg;

    always #5 clk = ~clk;

    led_dimmer_ctrl #(.DEBOUNCE_CYCLES(DEB), .STEP_TICKS(STEP)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .breathe_en (breathe_en),
        .duty_cycle (duty_cycle),
        .at_max     (at_max),
        .at_min     (at_min),
        .dbg        (dbg)
    );

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] exp_q[$];
    logic [3:0] model_duty;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits (bounded) for duty_cycle to move; elapsed = negedges waited.
    task automatic wait_change(input int budget, output int elapsed);
        logic [3:0] prev;
        prev    = duty_cycle;
        elapsed = 0;
        while (elapsed < budget && duty_cycle === prev) begin
            @(negedge clk);
            elapsed++;
        end
        n_checks++;
        assert (duty_cycle !== prev) else begin
            n_fail++;
            $error("FAIL change_timeout observed=%0d expected=change within %0d cycles", duty_cycle, budget);
        end
    endtask

    // Pops the next expected ramp value and compares it at the next change.
    task automatic step_check(input string tag, input int gap);
        logic [3:0] e;
        int         el;
        e = exp_q.pop_front();
        wait_change(20, el);
        chk({tag, "_duty"}, 32'(duty_cycle), 32'(e));
        chk({tag, "_at_max"}, 32'(at_max), 32'(e == 4'd15));
        chk({tag, "_at_min"}, 32'(at_min), 32'(e == 4'd0));
        if (gap > 0) chk({tag, "_gap"}, 32'(el), 32'(gap));
    endtask

    // Clean press: expected value from the bench model is queued when the
    // buttons are driven, then popped once the debounce latency has passed.
    task automatic press(input bit up, input bit down);
        logic [3:0] e;
        if (up && !down && model_duty != 4'd15) model_duty = model_duty + 4'd1;
        else if (down && !up && model_duty != 4'd0) model_duty = model_duty - 4'd1;
        exp_q.push_back(model_duty);
        btn_up   = up;
        btn_down = down;
        cycles(10);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        cycles(8);
        e = exp_q.pop_front();
        chk("press_duty", 32'(duty_cycle), 32'(e));
        chk("press_at_max", 32'(at_max), 32'(e == 4'd15));
        chk("press_at_min", 32'(at_min), 32'(e == 4'd0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int el;
        logic [3:0] e;

        // Reset
        reset = 1'b0;
        cycles(2);
        chk("rst_duty", 32'(duty_cycle), 32'd0);
        chk("rst_at_min", 32'(at_min), 32'd1);
        chk("rst_at_max", 32'(at_max), 32'd0);
        reset = 1'b1;
        cycles(1);
        chk("post_rst_duty", 32'(duty_cycle), 32'd0);
        chk("post_rst_state", 32'(dbg.state), 32'(MANUAL));
        model_duty = 4'd0;

        // Bouncing btn_up: 2-cycle toggles for 20 cycles, then held high
        for (int i = 0; i < 5; i++) begin
            btn_up = 1'b1;
            cycles(2);
            btn_up = 1'b0;
            cycles(2);
        end
        chk("bounce_no_change", 32'(duty_cycle), 32'd0);
        btn_up = 1'b1;
        wait_change(15, el);
        chk("bounce_duty", 32'(duty_cycle), 32'd1);
        chk("bounce_latency", 32'(el), 32'd7);
        cycles(5);
        chk("long_press_single", 32'(duty_cycle), 32'd1);
        btn_up = 1'b0;
        cycles(10);
        model_duty = 4'd1;

        // 3-cycle glitch
        btn_up = 1'b1;
        cycles(3);
        btn_up = 1'b0;
        cycles(15);
        chk("glitch_duty", 32'(duty_cycle), 32'd1);

        // Saturation up, simultaneous press, saturation down
        repeat (17) press(1'b1, 1'b0);
        chk("sat_max_duty", 32'(duty_cycle), 32'd15);
        chk("sat_max_flag", 32'(at_max), 32'd1);
        press(1'b1, 1'b1);
        repeat (20) press(1'b0, 1'b1);
        chk("sat_min_duty", 32'(duty_cycle), 32'd0);
        chk("sat_min_flag", 32'(at_min), 32'd1);

        // Breathe sweep from 13
        repeat (13) press(1'b1, 1'b0);
        exp_q.push_back(4'd14);
        exp_q.push_back(4'd15);
        for (int v = 14; v >= 0; v--) exp_q.push_back(4'(v));
        exp_q.push_back(4'd1);
        breathe_en = 1'b1;
        step_check("sweep_first", 6);
        while (exp_q.size() > 0) begin
            e = exp_q[0];
            step_check("sweep", STEP);
            if (e == 4'd15) chk("sweep_turn_down", 32'(dbg.state), 32'(RAMP_DOWN));
            if (e == 4'd0) chk("sweep_turn_up", 32'(dbg.state), 32'(RAMP_UP));
        end

        // btn_down press in breathe mode is ignored; exit at 7
        for (int v = 2; v <= 7; v++) exp_q.push_back(4'(v));
        step_check("ramp2", STEP);
        btn_down = 1'b1;
        step_check("ramp3", STEP);
        step_check("ramp4", STEP);
        step_check("ramp5", STEP);
        btn_down = 1'b0;
        step_check("ramp6", STEP);
        step_check("ramp7", STEP);
        breathe_en = 1'b0;
        cycles(10);
        chk("exit_hold_duty", 32'(duty_cycle), 32'd7);
        chk("exit_state", 32'(dbg.state), 32'(MANUAL));
        cycles(10);
        chk("exit_no_queued_press", 32'(duty_cycle), 32'd7);
        model_duty = 4'd7;
        press(1'b1, 1'b0);

        // Reset mid-ramp during RAMP_DOWN at 9
        repeat (7) press(1'b1, 1'b0);
        for (int v = 14; v >= 9; v--) exp_q.push_back(4'(v));
        breathe_en = 1'b1;
        step_check("down_first", 6);
        while (exp_q.size() > 0) step_check("down", STEP);
        chk("mid_ramp_state", 32'(dbg.state), 32'(RAMP_DOWN));
        reset      = 1'b0;
        breathe_en = 1'b0;
        cycles(1);
        chk("midrst_duty", 32'(duty_cycle), 32'd0);
        chk("midrst_at_min", 32'(at_min), 32'd1);
        chk("midrst_at_max", 32'(at_max), 32'd0);
        chk("midrst_state", 32'(dbg.state), 32'(MANUAL));
        reset = 1'b1;
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound in case something stalls outside the bounded waits.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/led_dimmer_ctrl.md
# led_dimmer_ctrl

Brightness controller that produces the 4-bit `duty_cycle` word consumed by `pwm_top`. It sits directly upstream of the PWM stage. It takes two raw push-buttons and a breathe-enable switch, then either steps brightness manually or ramps it up and down autonomously. Its output connects to `pwm_top.duty_cycle` with no glue logic.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a button level (10 ms at 50 MHz).
- `STEP_TICKS`, default 2500000: cycles between breathe steps (50 ms at 50 MHz).
- `clk`  in  1: system clock. This is the single clock domain.
- `reset`  in  1: synchronous, active-low reset.
- `btn_up`  in  1: raw, asynchronous, bouncy button (brighter).
- `btn_down`  in  1: raw, asynchronous, bouncy button (dimmer).
- `breathe_en`  in  1: level. 1 selects breathe mode. Synchronized internally.
- `duty_cycle`  out  4: brightness 0..15. Registered.
- `at_max`  out  1: registered. Equals 1 iff `duty_cycle == 15`.
- `at_min`  out  1: registered. Equals 1 iff `duty_cycle == 0`.

## Operation
- All three inputs pass through a 2-flop synchronizer.
- **Debounce, per button:**
  - A counter increments while the synchronized level differs from the debounced level.
  - The counter clears whenever the two levels match.
  - When the count reaches `DEBOUNCE_CYCLES-1`, the debounced level takes the new value and the counter clears.
  - A rising edge of the debounced level produces a 1-cycle `press` pulse.
- **FSM states:**
  - `MANUAL`: the reset state.
  - `RAMP_UP`.
  - `RAMP_DOWN`.
- **MANUAL:**
  - `press_up` alone increments `duty_cycle`, saturating at 15.
  - `press_down` alone decrements, saturating at 0.
  - Both presses in the same cycle: no change.
- **MANUAL → breathe:** when synchronized `breathe_en` = 1, go to `RAMP_DOWN` if `duty_cycle == 15`, otherwise `RAMP_UP`. The tick counter clears.
- **RAMP_UP / RAMP_DOWN:**
  - The tick counter counts 0..STEP_TICKS-1 and wraps.
  - On the wrap cycle, `duty_cycle` steps by ±1.
  - In `RAMP_UP`, the step that produces 15 also moves the state to `RAMP_DOWN`.
  - In `RAMP_DOWN`, the step that produces 0 also moves the state to `RAMP_UP`.
  - The endpoints are never overshot, and each endpoint is held for exactly one step period.
- **Buttons in breathe mode:** presses are ignored and discarded, not queued. Debouncers keep running.
- **breathe_en = 0** in either ramp state: return to `MANUAL` the next cycle. `duty_cycle` holds its current value and the tick counter clears.
- **Reset (any time, including mid-ramp or mid-debounce):**
  - `duty_cycle` = 0, `at_min` = 1, `at_max` = 0, state = `MANUAL`.
  - Synchronizers, debounced levels, debounce counters and the tick counter are all 0.

## Timing
- **Manual press latency:** a raw level change held stable at cycle 0 reaches the synchronized output at cycle 2. `press` is high at cycle 2+DEBOUNCE_CYCLES. `duty_cycle` updates at cycle 3+DEBOUNCE_CYCLES.
- **Bounce rejection:** any glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no `press`.
- **First breathe step:** `STEP_TICKS` cycles after the state enters a ramp state. Later steps are every `STEP_TICKS` cycles.
- **Flags:** `at_max` and `at_min` update in the same cycle as `duty_cycle` (derived from the next-state value, not lagging).
- **Release:** a button release needs no further action.
- **Long press:** holding a button gives exactly one step; there is no auto-repeat.

## Structure
- **Package `dimmer_pkg`:**
  - State enum `dim_state_t` with values `MANUAL`, `RAMP_UP`, `RAMP_DOWN`.
  - `DUTY_W` = 4.
  - `DUTY_MAX` = 4'd15.
  - `DUTY_MIN` = 4'd0.
- **Sub-module `btn_debounce`:**
  - Parameter: `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `reset`, `btn_raw` in; `btn_level`, `press` out.
  - Contains the synchronizer, the counter and the edge detector.
  - Instantiated twice.
- **Top level:** the `breathe_en` synchronizer, the FSM, the tick counter and the output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `STEP_TICKS`=3.

- **Reset:** `reset`=0 for 2 cycles, then release. Required: `duty_cycle`=0, `at_min`=1, `at_max`=0.
- **Debounce:**
  - `btn_up` toggling every 2 cycles for 20 cycles, then held 1. Required: exactly one increment, 0→1, at hold-start+7.
  - A 3-cycle glitch. Required: no change.
- **Saturation:**
  - 17 clean `btn_up` presses. Required: `duty_cycle`=15, `at_max`=1.
  - `btn_up` and `btn_down` pressed together. Required: no change.
  - 20 `btn_down` presses. Required: 0, `at_min`=1.
- **Breathe sweep from 13:** `breathe_en`=1. Required: steps 14, 15, 14, …, 1, 0, 1, spaced 3 cycles apart; state reverses at 15 and at 0.
- **Breathe exit:** `breathe_en`=0 mid-ramp at 7. Required: holds 7, back in `MANUAL`. A `btn_down` press while in breathe mode is ignored.
- **Reset mid-ramp:** `reset`=0 during `RAMP_DOWN` at value 9. Required: next cycle `duty_cycle`=0, state `MANUAL`.
